// File: rtl/wn_phase_decompensation.sv
// wn_phase_decompensation: removes per-symbol carrier phase pre-compensation by
// multiplying each IQ sample with the conjugate of the symbol's phase word.
`default_nettype none

module wn_phase_decompensation #(
   parameter int SC_PER_SYMBOL    = 1584,
   parameter int SYMBOLS_PER_SLOT = 14
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [7:0]  config_in_tdata,
   input  logic        config_in_tvalid,
   output logic        config_in_tready,
   input  logic [31:0] phase_in_tdata,
   input  logic        phase_in_tvalid,
   output logic        phase_in_tready,
   input  logic [31:0] data_in_tdata,
   input  logic        data_in_tlast,
   input  logic        data_in_tvalid,
   output logic        data_in_tready,
   output logic [31:0] data_out_tdata,
   output logic        data_out_tlast,
   output logic        data_out_tvalid,
   input  logic        data_out_tready,
   output logic        tlast_error
);

   localparam int SC_W  = (SC_PER_SYMBOL > 1)    ? $clog2(SC_PER_SYMBOL)    : 1;
   localparam int SYM_W = (SYMBOLS_PER_SLOT > 1) ? $clog2(SYMBOLS_PER_SLOT) : 1;
   localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SC_PER_SYMBOL - 1);
   localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYMBOLS_PER_SLOT - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             run;
   logic             enable;
   logic [15:0]      phase_cos;
   logic [15:0]      phase_sin;
   logic [SC_W-1:0]  sc;
   logic [SYM_W-1:0] sym;

   logic advance;
   logic cfg_xfer;
   logic phase_xfer;
   logic data_xfer;
   logic sym_done;
   logic slot_last;
   logic unused_cfg_bits;

   logic signed [15:0] dr, di, pr, pi;

   logic               s1_valid, s1_last, s1_bypass;
   logic [31:0]        s1_raw;
   logic signed [31:0] pp_rr, pp_ii, pp_ir, pp_ri;
   logic               s2_valid, s2_last, s2_bypass;
   logic [31:0]        s2_raw;
   logic signed [32:0] sum_r, sum_i;

   function automatic logic [15:0] round_sat(input logic signed [32:0] s);
      logic signed [33:0] r;
      r = (34'(s) + 34'sd16384) >>> 15;
      if (r > 34'sd32767)
         return 16'h7FFF;
      else if (r < -34'sd32768)
         return 16'h8000;
      else
         return r[15:0];
   endfunction

   assign unused_cfg_bits = ^config_in_tdata[7:1];

   assign advance    = !data_out_tvalid || data_out_tready;
   assign cfg_xfer   = config_in_tvalid && config_in_tready;
   assign phase_xfer = phase_in_tvalid && phase_in_tready;
   assign data_xfer  = data_in_tvalid && data_in_tready;
   assign sym_done   = data_xfer && (sc == SC_LAST);
   assign slot_last  = (sc == SC_LAST) && (sym == SYM_LAST);

   assign dr = data_in_tdata[15:0];
   assign di = data_in_tdata[31:16];
   assign pr = phase_cos;
   assign pi = phase_sin;

   // run holds every ready low during reset and for the first edge after release
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         run   <= 1'b0;
      end else begin
         state <= state_nxt;
         run   <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (cfg_xfer)   state_nxt = S_LOAD;
         S_LOAD:   if (phase_xfer) state_nxt = S_STREAM;
         S_STREAM: if (sym_done)   state_nxt = (sym == SYM_LAST) ? S_IDLE : S_LOAD;
         default:                  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      config_in_tready = run && (state == S_IDLE);
      phase_in_tready  = run && (state == S_LOAD);
      data_in_tready   = run && (state == S_STREAM) && advance;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         enable      <= 1'b0;
         phase_cos   <= 16'd0;
         phase_sin   <= 16'd0;
         sc          <= '0;
         sym         <= '0;
         tlast_error <= 1'b0;
      end else begin
         if (cfg_xfer)
            enable <= config_in_tdata[0];
         if (phase_xfer) begin
            phase_cos <= phase_in_tdata[15:0];
            phase_sin <= phase_in_tdata[31:16];
         end
         if (data_xfer) begin
            if (data_in_tlast != slot_last)
               tlast_error <= 1'b1;
            if (sc == SC_LAST) begin
               sc  <= '0;
               sym <= (sym == SYM_LAST) ? '0 : sym + SYM_W'(1);
            end else begin
               sc <= sc + SC_W'(1);
            end
         end
      end
   end

   // All three stages move together; each sample carries its own phase products and flags
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid        <= 1'b0;
         s1_last         <= 1'b0;
         s1_bypass       <= 1'b0;
         s1_raw          <= '0;
         pp_rr           <= '0;
         pp_ii           <= '0;
         pp_ir           <= '0;
         pp_ri           <= '0;
         s2_valid        <= 1'b0;
         s2_last         <= 1'b0;
         s2_bypass       <= 1'b0;
         s2_raw          <= '0;
         sum_r           <= '0;
         sum_i           <= '0;
         data_out_tvalid <= 1'b0;
         data_out_tlast  <= 1'b0;
         data_out_tdata  <= '0;
      end else if (advance) begin
         s1_valid <= data_xfer;
         if (data_xfer) begin
            s1_last   <= slot_last;
            s1_bypass <= !enable;
            s1_raw    <= data_in_tdata;
            pp_rr     <= dr * pr;
            pp_ii     <= di * pi;
            pp_ir     <= di * pr;
            pp_ri     <= dr * pi;
         end
         s2_valid  <= s1_valid;
         s2_last   <= s1_last;
         s2_bypass <= s1_bypass;
         s2_raw    <= s1_raw;
         sum_r     <= 33'(pp_rr) + 33'(pp_ii);
         sum_i     <= 33'(pp_ir) - 33'(pp_ri);
         data_out_tvalid <= s2_valid;
         data_out_tlast  <= s2_valid && s2_last;
         data_out_tdata  <= s2_bypass ? s2_raw : {round_sat(sum_i), round_sat(sum_r)};
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_wn_phase_decompensation.sv
// Scoreboard bench for wn_phase_decompensation: stimulus pushes expected samples,
// a monitor pops and compares each accepted output.
`default_nettype none

module tb_wn_phase_decompensation;

   localparam int SC   = 48;
   localparam int SYM  = 14;
   localparam int SLOT = SC * SYM;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  config_in_tdata = '0;
   logic        config_in_tvalid = 1'b0;
   logic        config_in_tready;
   logic [31:0] phase_in_tdata = '0;
   logic        phase_in_tvalid = 1'b0;
   logic        phase_in_tready;
   logic [31:0] data_in_tdata = '0;
   logic        data_in_tlast = 1'b0;
   logic        data_in_tvalid = 1'b0;
   logic        data_in_tready;
   logic [31:0] data_out_tdata;
   logic        data_out_tlast;
   logic        data_out_tvalid;
   logic        data_out_tready = 1'b0;
   logic        tlast_error;

   typedef struct {
      logic [31:0] data;
      bit          last;
      bit          lat;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   out_count = 0;
   int   phase_pulses = 0;
   int   bp_cnt = 0;
   int   lat_d;
   bit   bp = 1'b0;
   bit   prev_pr = 1'b0;

   wn_phase_decompensation #(.SC_PER_SYMBOL(SC), .SYMBOLS_PER_SLOT(SYM)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .config_in_tdata  (config_in_tdata),
      .config_in_tvalid (config_in_tvalid),
      .config_in_tready (config_in_tready),
      .phase_in_tdata   (phase_in_tdata),
      .phase_in_tvalid  (phase_in_tvalid),
      .phase_in_tready  (phase_in_tready),
      .data_in_tdata    (data_in_tdata),
      .data_in_tlast    (data_in_tlast),
      .data_in_tvalid   (data_in_tvalid),
      .data_in_tready   (data_in_tready),
      .data_out_tdata   (data_out_tdata),
      .data_out_tlast   (data_out_tlast),
      .data_out_tvalid  (data_out_tvalid),
      .data_out_tready  (data_out_tready),
      .tlast_error      (tlast_error)
   );

   initial forever #5 clock = ~clock;
   initial forever begin @(posedge clock); cyc = cyc + 1; end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   function automatic logic [15:0] sat(input longint v);
      longint r;
      r = (v + 16384) >>> 15;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return r[15:0];
   endfunction

   function automatic logic [31:0] golden(input logic [31:0] d, input logic [31:0] p, input bit en);
      longint dr, di, pr, pi;
      if (!en) return d;
      dr = longint'($signed(d[15:0]));
      di = longint'($signed(d[31:16]));
      pr = longint'($signed(p[15:0]));
      pi = longint'($signed(p[31:16]));
      return {sat(di * pr - dr * pi), sat(dr * pr + di * pi)};
   endfunction

   // Downstream ready: always high, or high one cycle in three
   initial forever begin
      @(posedge clock); #1;
      if (bp) begin
         bp_cnt = bp_cnt + 1;
         data_out_tready = (bp_cnt % 3 == 0);
      end else begin
         data_out_tready = 1'b1;
      end
   end

   initial forever begin
      @(negedge clock);
      if (phase_in_tready && !prev_pr) phase_pulses = phase_pulses + 1;
      prev_pr = phase_in_tready;
   end

   initial forever begin
      @(negedge clock);
      if (reset_n && data_out_tvalid && data_out_tready) begin
         if (exp_q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_output: got %h with empty scoreboard", data_out_tdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("out_data", data_out_tdata, mon_e.data);
            chk("out_last", 32'(data_out_tlast), 32'(mon_e.last));
            if (mon_e.lat) begin
               lat_d = cyc - mon_e.cyc;
               chk("latency_within_3", 32'(lat_d >= 1 && lat_d <= 3), 32'd1);
            end
         end
         out_count = out_count + 1;
      end
   end

   task automatic send_config(input logic [7:0] cfg);
      bit got = 1'b0;
      config_in_tdata  = cfg;
      config_in_tvalid = 1'b1;
      for (int n = 0; n < 64 && !got; n++) begin
         @(negedge clock); got = config_in_tready; @(posedge clock); #1;
      end
      config_in_tvalid = 1'b0;
      if (!got) timeout("config_in_tready");
   endtask

   task automatic send_phase(input logic [31:0] p);
      bit got = 1'b0;
      phase_in_tdata  = p;
      phase_in_tvalid = 1'b1;
      for (int n = 0; n < 64 && !got; n++) begin
         @(negedge clock); got = phase_in_tready; @(posedge clock); #1;
      end
      phase_in_tvalid = 1'b0;
      if (!got) timeout("phase_in_tready");
   endtask

   task automatic send_data(input logic [31:0] d, input bit tl, input logic [31:0] ed,
                            input bit el, input bit lat);
      exp_t e;
      bit   got = 1'b0;
      data_in_tdata  = d;
      data_in_tlast  = tl;
      data_in_tvalid = 1'b1;
      for (int n = 0; n < 64 && !got; n++) begin
         @(negedge clock); got = data_in_tready; @(posedge clock); #1;
      end
      data_in_tvalid = 1'b0;
      data_in_tlast  = 1'b0;
      if (!got) timeout("data_in_tready");
      e.data = ed; e.last = el; e.lat = lat; e.cyc = cyc;
      exp_q.push_back(e);
   endtask

   // kind: 0 random, 1 directed first samples, 2 misplaced input tlast, 3 stop after 500
   task automatic run_slot(input bit en, input int kind);
      logic [31:0] ph, d, ed;
      bit          il, tl, lat;
      int          idx = 0;
      send_config({7'h55, en});
      for (int s = 0; s < SYM; s++) begin
         ph = $urandom;
         if (kind == 1 && s == 0) ph = 32'h7FFF_0000;
         if (kind == 1 && s == 1) ph = 32'h8000_8000;
         send_phase(ph);
         for (int c = 0; c < SC; c++) begin
            if (kind == 3 && idx == 500) return;
            d   = $urandom;
            il  = (s == SYM - 1) && (c == SC - 1);
            ed  = golden(d, ph, en);
            lat = 1'b0;
            if (kind == 1 && s == 0 && c == 0) begin
               d = 32'h07D0_03E8; ed = 32'hFC18_07D0; lat = 1'b1;
            end
            if (kind == 1 && s == 1 && c == 0) begin
               d = 32'h8000_8000; ed = 32'h0000_7FFF;
            end
            tl = (kind == 2) ? (idx == 99) : il;
            if (kind == 2 && idx == 99) chk("tlast_error_before", 32'(tlast_error), 32'd0);
            send_data(d, tl, ed, il, lat);
            if (kind == 2 && idx == 99) chk("tlast_error_after", 32'(tlast_error), 32'd1);
            idx = idx + 1;
         end
      end
   endtask

   task automatic drain_and_check(input string name);
      for (int n = 0; n < 400 && (exp_q.size() != 0 || data_out_tvalid); n++)
         @(posedge clock);
      #1;
      if (exp_q.size() != 0) timeout({name, "_drain"});
      chk({name, "_out_count"}, 32'(out_count), 32'(SLOT));
      chk({name, "_back_to_idle"}, 32'(config_in_tready), 32'd1);
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      chk("rst_outputs", {config_in_tready, phase_in_tready, data_in_tready,
                          data_out_tvalid, data_out_tlast, tlast_error}, 32'd0);
      chk("rst_data", data_out_tdata, 32'd0);
      @(negedge clock); reset_n = 1'b1;

      out_count = 0;
      run_slot(1'b1, 1);
      drain_and_check("directed_slot");

      out_count = 0; phase_pulses = 0;
      run_slot(1'b0, 0);
      drain_and_check("bypass_slot");
      chk("bypass_phase_pulses", 32'(phase_pulses), 32'd14);

      out_count = 0; bp = 1'b1;
      run_slot(1'b1, 0);
      drain_and_check("backpressure_slot");
      bp = 1'b0;

      out_count = 0;
      run_slot(1'b1, 2);
      drain_and_check("tlast_err_slot");
      chk("tlast_error_sticky", 32'(tlast_error), 32'd1);

      out_count = 0;
      run_slot(1'b1, 3);
      #2; reset_n = 1'b0; #1;
      chk("midrst_outputs", {config_in_tready, phase_in_tready, data_in_tready,
                             data_out_tvalid, data_out_tlast, tlast_error}, 32'd0);
      chk("midrst_data", data_out_tdata, 32'd0);
      exp_q.delete();
      @(negedge clock); reset_n = 1'b1; #1;
      chk("release_cfg_ready_low", 32'(config_in_tready), 32'd0);
      @(posedge clock); #1;
      chk("release_cfg_ready_high", 32'(config_in_tready), 32'd1);
      out_count = 0;
      run_slot(1'b1, 0);
      drain_and_check("post_reset_slot");
      chk("post_reset_tlast_error", 32'(tlast_error), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
